billing_arbiter: RTL and testbench

Round-robin controller that shares the single billing engine (meter lookup, units query, bill amount, payment update) between four customer kiosks. Accepts one request at a time, sequences the engine through a start/done handshake with timeout, and returns the result to the originating kiosk. It sits between the kiosk front-ends and the billing datapath, and it is the only block that drives the engine's start.

---
 rtl/billing_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_billing_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/billing_arbiter.sv
// Round-robin arbiter sharing one billing engine across four kiosks; all outputs registered.
// Latency: ack+start 1 cycle after sample, response 1 cycle after eng_done (or timeout); losers stay pending.
module billing_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_METERS = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_meter,
  input  logic [2*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic                   eng_start,
  output logic [3:0]             eng_meter,
  output logic [1:0]             eng_op,
  output logic                   eng_abort,
  input  logic                   eng_done,
  input  logic [15:0]            eng_result,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_id,
  output logic [15:0]            rsp_data,
  output logic [1:0]             rsp_err,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [4:0] METER_LIM = 5'(NUM_METERS);
  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic                 eng_start_q, eng_start_d;
  logic                 eng_abort_q, eng_abort_d;
  logic [3:0]           eng_meter_q, eng_meter_d;
  logic [1:0]           eng_op_q, eng_op_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_id_q, rsp_id_d;
  logic [15:0]          rsp_data_q, rsp_data_d;
  logic [1:0]           rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;
  logic [1:0]           last_grant_q, last_grant_d;
  logic [1:0]           id_q, id_d;
  logic [7:0]           cnt_q, cnt_d;

  logic                 win_vld;
  logic [1:0]           win_id;
  logic [1:0]           idx;
  logic [3:0]           sel_meter;
  logic [1:0]           sel_op;

  // Walk from farthest to nearest so the kiosk right after last_grant wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last_grant_q + 2'(k);
      if (req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign sel_meter = req_meter[{win_id, 2'b00} +: 4];
  assign sel_op    = req_op[{win_id, 1'b0} +: 2];

  always_comb begin
    state_d      = state_q;
    req_ack_d    = '0;
    eng_start_d  = 1'b0;
    eng_abort_d  = 1'b0;
    rsp_valid_d  = 1'b0;
    eng_meter_d  = eng_meter_q;
    eng_op_d     = eng_op_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          id_d              = win_id;
          req_ack_d[win_id] = 1'b1;
          if ({1'b0, sel_meter} >= METER_LIM || sel_op == 2'd3) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_id;
            rsp_data_d  = '0;
            rsp_err_d   = ({1'b0, sel_meter} >= METER_LIM) ? 2'd1 : 2'd2;
          end else begin
            state_d     = S_ISSUE;
            eng_start_d = 1'b1;
            eng_meter_d = sel_meter;
            eng_op_d    = sel_op;
            cnt_d       = '0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (eng_done) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = eng_result;
          rsp_err_d   = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          eng_abort_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = '0;
          rsp_err_d   = 2'd3;
        end
      end
      S_RESP: begin
        last_grant_d = id_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ack_q    <= '0;
      eng_start_q  <= 1'b0;
      eng_abort_q  <= 1'b0;
      eng_meter_q  <= '0;
      eng_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= '0;
      busy_q       <= 1'b0;
      last_grant_q <= 2'd3;
      id_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ack_q    <= req_ack_d;
      eng_start_q  <= eng_start_d;
      eng_abort_q  <= eng_abort_d;
      eng_meter_q  <= eng_meter_d;
      eng_op_q     <= eng_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign eng_start = eng_start_q;
  assign eng_abort = eng_abort_q;
  assign eng_meter = eng_meter_q;
  assign eng_op    = eng_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_billing_arbiter.sv
// Directed bench for billing_arbiter: kiosk requests, a simple engine responder and a response scoreboard.
module tb_billing_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_meter;
  logic [7:0]  req_op;
  logic [3:0]  req_ack;
  logic        eng_start;
  logic [3:0]  eng_meter;
  logic [1:0]  eng_op;
  logic        eng_abort;
  logic        eng_done = 1'b0;
  logic [15:0] eng_result = 16'h0;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;

  billing_arbiter #(.NUM_REQ(4), .NUM_METERS(10), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_meter(req_meter), .req_op(req_op), .req_ack(req_ack),
    .eng_start(eng_start), .eng_meter(eng_meter), .eng_op(eng_op), .eng_abort(eng_abort),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic [1:0]  err;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_start = 0, n_abort = 0, n_rsp = 0;

  // Engine model: answers eng_delay cycles after eng_start with eng_base + meter; 0 means never.
  int          eng_delay = 1;
  int          eng_cnt = -1;
  logic [15:0] eng_base = 16'd0;
  logic [15:0] eng_pend = 16'd0;
  logic        force_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input int id, input int data, input int err);
    rsp_t e;
    e.id   = 2'(id);
    e.data = 16'(data);
    e.err  = 2'(err);
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (eng_start === 1'b1) n_start++;
    if (eng_abort === 1'b1) n_abort++;
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      if (sb.size() > 0) mon_e = sb.pop_front();
      else mon_e = '1;
      chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
      chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
      chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
    end
  end

  always @(negedge clk) begin
    eng_done   = force_done;
    eng_result = 16'hBEEF;
    if (rst) eng_cnt = -1;
    else begin
      if (eng_cnt == 0) begin
        eng_done   = 1'b1;
        eng_result = eng_pend;
      end
      if (eng_cnt >= 0) eng_cnt--;
      if (eng_start === 1'b1 && eng_delay > 0) begin
        eng_cnt  = eng_delay - 1;
        eng_pend = eng_base + {12'd0, eng_meter};
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_req(input int id, input logic [3:0] m, input logic [1:0] op);
    req_valid[id]      = 1'b1;
    req_meter[id*4 +: 4] = m;
    req_op[id*2 +: 2]    = op;
  endtask

  task automatic wait_ack(input string tag, input logic [3:0] exp, input bit keep, output int at);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ack === 4'b0 && n < 12);
    chk(tag, 32'(req_ack), 32'(exp));
    if (!keep) req_valid = req_valid & ~req_ack;
    at = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < 150) begin
      tick();
      n++;
    end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  int at, prev, s0, r0, a0;
  int bad_id[5]  = '{1, 3, 0, 2, 1};
  int bad_m[5]   = '{12, 4, 15, 10, 9};
  int bad_op[5]  = '{0, 3, 3, 0, 2};
  int bad_err[5] = '{1, 2, 1, 1, 0};

  initial begin
    rst = 1'b1; req_valid = '0; req_meter = '0; req_op = '0;
    repeat (2) tick();
    chk("rst_req_ack", 32'(req_ack), 0);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_eng_abort", 32'(eng_abort), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_eng_meter", 32'(eng_meter), 0);
    chk("rst_eng_op", 32'(eng_op), 0);
    rst = 1'b0;

    // Fairness: all four held high, grants rotate 0,1,2,3,0 every 4 cycles.
    eng_delay = 1; eng_base = 16'd100;
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 2'd0);
    for (int g = 0; g < 5; g++) push(g % 4, 100 + (g % 4) + 1, 0);
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ack("fair_ack", 4'(1 << (g % 4)), g < 4, at);
      if (g > 0) chk("fair_spacing", at - prev, 4);
      prev = at;
    end
    req_valid = '0;
    wait_idle("fair_idle");

    // Single request, done two cycles after start.
    eng_delay = 2; eng_base = 16'd1205;
    set_req(2, 4'd5, 2'd1);
    push(2, 1210, 0);
    wait_ack("single_ack", 4'b0100, 1'b0, at);
    chk("single_start", 32'(eng_start), 1);
    chk("single_meter", 32'(eng_meter), 5);
    chk("single_op", 32'(eng_op), 1);
    chk("single_busy", 32'(busy), 1);
    tick(); tick();
    chk("single_no_early_rsp", 32'(rsp_valid), 0);
    tick();
    chk("single_rsp_cycle", 32'(rsp_valid), 1);
    chk("single_meter_hold", 32'(eng_meter), 5);
    wait_idle("single_idle");

    // Bad meter / bad op (meter check wins), plus boundary meters 10 and 9.
    eng_delay = 1; eng_base = 16'd0;
    for (int t = 0; t < 5; t++) begin
      s0 = n_start;
      set_req(bad_id[t], 4'(bad_m[t]), 2'(bad_op[t]));
      push(bad_id[t], (bad_err[t] == 0) ? bad_m[t] : 0, bad_err[t]);
      wait_ack("bad_ack", 4'(1 << bad_id[t]), 1'b0, at);
      if (bad_err[t] != 0) chk("bad_rsp_with_ack", 32'(rsp_valid), 1);
      else chk("good_start_with_ack", 32'(eng_start), 1);
      wait_idle("bad_idle");
      chk("bad_start_count", n_start - s0, (bad_err[t] == 0) ? 1 : 0);
    end

    // Timeout: abort and response in the cycle after the 64th WAIT cycle.
    eng_delay = 0;
    r0 = n_rsp; a0 = n_abort;
    set_req(0, 4'd3, 2'd2);
    push(0, 0, 3);
    wait_ack("to_ack", 4'b0001, 1'b0, at);
    s0 = at;
    for (int n = 0; n < 80 && eng_abort !== 1'b1; n++) tick();
    chk("to_abort_cycle", cyc - s0, 65);
    chk("to_rsp_with_abort", 32'(rsp_valid), 1);
    tick();
    force_done = 1'b1;
    tick(); tick();
    force_done = 1'b0;
    chk("late_done_busy", 32'(busy), 0);
    wait_idle("to_idle");
    chk("to_rsp_count", n_rsp - r0, 1);
    chk("to_abort_count", n_abort - a0, 1);

    // Reset five cycles into WAIT.
    r0 = n_rsp; a0 = n_abort;
    set_req(1, 4'd2, 2'd0);
    wait_ack("rw_ack", 4'b0010, 1'b0, at);
    repeat (5) tick();
    chk("rw_busy_before", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("rw_busy_now", 32'(busy), 0);
    chk("rw_meter_now", 32'(eng_meter), 0);
    chk("rw_start_now", 32'(eng_start), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rw_no_rsp", n_rsp - r0, 0);
    chk("rw_no_abort", n_abort - a0, 0);

    // After reset kiosk 0 has priority over kiosk 2.
    eng_delay = 1; eng_base = 16'd500;
    set_req(2, 4'd7, 2'd1);
    set_req(0, 4'd6, 2'd0);
    push(0, 506, 0);
    push(2, 507, 0);
    wait_ack("post_rst_first", 4'b0001, 1'b0, at);
    wait_ack("post_rst_second", 4'b0100, 1'b0, at);
    wait_idle("post_rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
